ram_1p_arbiter: RTL and testbench

//  Shares one single-port 32-bit SRAM (1-cycle read latency, rvalid = req delayed 1 cycle) between
//  the core instruction port (read-only) and data port (read/write) in the simple system.

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_arb_sel.sv | 68 ++++++
 rtl/ram_1p_arbiter.sv | 110 +++++++++++
 tb/tb_ram_1p_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// The optional RAM_ARB_ROUND_ROBIN_EN macro is consumed by ram_arb_sel.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_INSTR = 2'd1,
        OWNER_DATA  = 2'd2
    } owner_e;

    localparam int unsigned DefaultDepth = 128;
    localparam int unsigned RamAw        = $clog2(DefaultDepth);

    // True when addr lies in [base_addr, base_addr + 4*depth).
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base_addr,
                                           input int unsigned depth);
        return (addr >= base_addr) && ((addr - base_addr) < (32'(depth) << 2));
    endfunction

endpackage

// File: rtl/ram_arb_sel.sv
// Per-cycle grant selection between the instruction and data ports.
// Fixed data priority with MaxWait anti-starvation, or alternation when RAM_ARB_ROUND_ROBIN_EN is defined.
module ram_arb_sel
    import ram_arb_pkg::*;
#(
    parameter int unsigned MaxWait = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_instr_req,
    input  logic i_data_req,
    output logic o_instr_gnt,
    output logic o_data_gnt
);

    logic w_instr_wins;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    owner_e r_last;

    assign w_instr_wins = (r_last == OWNER_DATA);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= OWNER_INSTR;
        end else if (o_instr_gnt) begin
            r_last <= OWNER_INSTR;
        end else if (o_data_gnt) begin
            r_last <= OWNER_DATA;
        end
    end
`else
    localparam int unsigned      WaitW   = $clog2(MaxWait + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

    logic [WaitW-1:0] r_wait_cnt;

    assign w_instr_wins = (r_wait_cnt == WaitMax);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
        end else if (i_instr_req && !o_instr_gnt) begin
            r_wait_cnt <= (r_wait_cnt == WaitMax) ? r_wait_cnt : r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`endif

    // NOTE: both grants get a default first so no path through the block can infer a latch.
    always_comb begin
        o_instr_gnt = 1'b0;
        o_data_gnt  = 1'b0;
        if (!rst_i) begin
            if (i_instr_req && i_data_req) begin
                o_instr_gnt = w_instr_wins;
                o_data_gnt  = !w_instr_wins;
            end else begin
                o_instr_gnt = i_instr_req;
                o_data_gnt  = i_data_req;
            end
        end
    end

endmodule

// File: rtl/ram_1p_arbiter.sv
// Shares one single-port SRAM between the instruction (read-only) and data ports.
// Build with RAM_ARB_ROUND_ROBIN_EN for alternating grants instead of fixed data priority.
module ram_1p_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0010_0000,
    parameter int unsigned MaxWait  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    logic   w_instr_gnt;
    logic   w_data_gnt;
    logic   w_instr_in_range;
    logic   w_data_in_range;
    logic   w_instr_hit;
    logic   w_data_hit;
    logic   w_rsp_live;
    owner_e r_rsp_owner;
    logic   r_rsp_err;

    ram_arb_sel #(
        .MaxWait (MaxWait)
    ) u_sel (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_instr_req (instr_req_i),
        .i_data_req  (data_req_i),
        .o_instr_gnt (w_instr_gnt),
        .o_data_gnt  (w_data_gnt)
    );

    assign w_instr_in_range = addr_in_range(instr_addr_i, BaseAddr, Depth);
    assign w_data_in_range  = addr_in_range(data_addr_i, BaseAddr, Depth);
    assign w_instr_hit      = w_instr_gnt & w_instr_in_range;
    assign w_data_hit       = w_data_gnt & w_data_in_range;

    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_gnt;

    // Out-of-range grants never reach the RAM, so dropped writes cost nothing.
    assign ram_req_o = w_instr_hit | w_data_hit;
    assign ram_we_o  = w_data_hit & data_we_i;

    always_comb begin
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (w_instr_hit) begin
            ram_be_o   = 4'hF;
            ram_addr_o = instr_addr_i - BaseAddr;
        end else if (w_data_hit) begin
            ram_be_o    = data_be_i;
            ram_addr_o  = data_addr_i - BaseAddr;
            ram_wdata_o = data_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_owner <= OWNER_NONE;
            r_rsp_err   <= 1'b0;
        end else if (w_instr_gnt) begin
            r_rsp_owner <= OWNER_INSTR;
            r_rsp_err   <= !w_instr_in_range;
        end else if (w_data_gnt) begin
            r_rsp_owner <= OWNER_DATA;
            r_rsp_err   <= !w_data_in_range;
        end else begin
            r_rsp_owner <= OWNER_NONE;
            r_rsp_err   <= 1'b0;
        end
    end

    // Gating with rst_i drops a response still in flight when reset lands mid-transaction.
    assign w_rsp_live = !rst_i & (ram_rvalid_i | r_rsp_err);

    assign instr_rvalid_o = w_rsp_live & (r_rsp_owner == OWNER_INSTR);
    assign instr_err_o    = instr_rvalid_o & r_rsp_err;
    assign instr_rdata_o  = (instr_rvalid_o && !r_rsp_err) ? ram_rdata_i : '0;

    assign data_rvalid_o  = w_rsp_live & (r_rsp_owner == OWNER_DATA);
    assign data_err_o     = data_rvalid_o & r_rsp_err;
    assign data_rdata_o   = (data_rvalid_o && !r_rsp_err) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// Self-checking bench for ram_1p_arbiter: SRAM model, reference model compare process, directed tests.
// Build with RAM_ARB_ROUND_ROBIN_EN defined to check the round-robin variant.
module tb_ram_1p_arbiter;

    localparam int unsigned Depth   = 128;
    localparam logic [31:0] Base    = 32'h0010_0000;
    localparam int unsigned MaxWait = 4;

    logic        clk;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        ram_req;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_rvalid;
    logic [31:0] ram_rdata;
    logic        preload;

    int checks   = 0;
    int failures = 0;

    ram_1p_arbiter #(
        .Depth    (Depth),
        .BaseAddr (Base),
        .MaxWait  (MaxWait)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .ram_req_o      (ram_req),
        .ram_we_o       (ram_we),
        .ram_be_o       (ram_be),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rvalid_i   (ram_rvalid),
        .ram_rdata_i    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'hFFFF_FFFF;
        if (i == 2) return 32'hDEAD_BEEF;
        return 32'h5A00_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return (a >= Base) && (a < Base + 4 * Depth);
    endfunction

    // SRAM model: one-cycle read latency, rvalid is req delayed by one cycle, never reset.
    logic [31:0] sram [Depth];
    always @(posedge clk) begin
        ram_rvalid <= ram_req;
        if (preload) begin
            for (int i = 0; i < Depth; i++) sram[i] <= init_word(i);
        end else if (ram_req) begin
            if (ram_we) begin
                sram[ram_addr[31:2] % Depth] <= merge(sram[ram_addr[31:2] % Depth], ram_wdata, ram_be);
                ram_rdata <= 32'h0;
            end else begin
                ram_rdata <= sram[ram_addr[31:2] % Depth];
            end
        end
    end

    // Reference model: expected response owner/data from the previous grant, starvation age, last winner.
    typedef struct {
        int          owner;
        logic        err;
        logic        is_write;
        logic [31:0] rdata;
    } rsp_t;

    logic [31:0] model_mem [Depth];
    rsp_t        exp_rsp;
    int          stall_age;
    logic        last_was_data;

    always @(negedge clk) begin : compare_p
        logic exp_ig;
        logic exp_dg;
        logic ir;
        logic dr;
        logic instr_first;
        int   idx;
        if (preload) begin
            for (int i = 0; i < Depth; i++) model_mem[i] = init_word(i);
        end
        if (rst) begin
            check("rst_instr_gnt", instr_gnt, 0);
            check("rst_data_gnt", data_gnt, 0);
            check("rst_ram_req", ram_req, 0);
            check("rst_instr_rvalid", instr_rvalid, 0);
            check("rst_data_rvalid", data_rvalid, 0);
            check("rst_instr_err", instr_err, 0);
            check("rst_data_err", data_err, 0);
            check("rst_instr_rdata", instr_rdata, 0);
            check("rst_data_rdata", data_rdata, 0);
            exp_rsp       = '{0, 1'b0, 1'b0, 32'h0};
            stall_age     = 0;
            last_was_data = 1'b0;
        end else begin
            check("m_instr_rvalid", instr_rvalid, exp_rsp.owner == 1);
            check("m_data_rvalid", data_rvalid, exp_rsp.owner == 2);
            if (exp_rsp.owner == 1) begin
                check("m_instr_err", instr_err, exp_rsp.err);
                check("m_instr_rdata", instr_rdata, exp_rsp.rdata);
            end
            if (exp_rsp.owner == 2) begin
                check("m_data_err", data_err, exp_rsp.err);
                if (!exp_rsp.is_write) check("m_data_rdata", data_rdata, exp_rsp.rdata);
            end

`ifdef RAM_ARB_ROUND_ROBIN_EN
            instr_first = last_was_data;
`else
            instr_first = (stall_age >= MaxWait);
`endif
            exp_ig = instr_req && (!data_req || instr_first);
            exp_dg = data_req && !exp_ig;
            ir     = in_range(instr_addr);
            dr     = in_range(data_addr);
            check("m_instr_gnt", instr_gnt, exp_ig);
            check("m_data_gnt", data_gnt, exp_dg);
            check("m_ram_req", ram_req, (exp_ig && ir) || (exp_dg && dr));
            if (exp_ig && ir) begin
                check("m_ram_addr_i", ram_addr, instr_addr - Base);
                check("m_ram_we_i", ram_we, 0);
                check("m_ram_be_i", ram_be, 4'hF);
            end
            if (exp_dg && dr) begin
                check("m_ram_addr_d", ram_addr, data_addr - Base);
                check("m_ram_we_d", ram_we, data_we);
                check("m_ram_be_d", ram_be, data_be);
                if (data_we) check("m_ram_wdata", ram_wdata, data_wdata);
            end

            exp_rsp = '{0, 1'b0, 1'b0, 32'h0};
            if (exp_ig) begin
                idx     = int'((instr_addr - Base) >> 2);
                exp_rsp = '{1, !ir, 1'b0, ir ? model_mem[idx] : 32'h0};
            end else if (exp_dg) begin
                idx     = int'((data_addr - Base) >> 2);
                exp_rsp = '{2, !dr, data_we, (dr && !data_we) ? model_mem[idx] : 32'h0};
                if (dr && data_we) model_mem[idx] = merge(model_mem[idx], data_wdata, data_be);
            end
            stall_age = (instr_req && !exp_ig) ? stall_age + 1 : 0;
            if (exp_ig) last_was_data = 1'b0;
            else if (exp_dg) last_was_data = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        logic [79:0] exp_seq;
        logic [7:0]  got_c;

        rst = 1'b1; preload = 1'b1;
        instr_req = 1'b0; instr_addr = Base;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'hF; data_addr = Base; data_wdata = '0;
        repeat (3) step();
        rst = 1'b0; preload = 1'b0;

        // 1: lone instruction fetch of a preloaded word
        step();
        instr_req = 1'b1; instr_addr = Base + 32'd8;
        @(negedge clk);
        check("t1_gnt", instr_gnt, 1);
        step();
        instr_req = 1'b0;
        @(negedge clk);
        check("t1_rvalid", instr_rvalid, 1);
        check("t1_rdata", instr_rdata, 32'hDEAD_BEEF);
        check("t1_err", instr_err, 0);

        // 2: partial write then read back
        step();
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
        data_addr = Base + 32'd4; data_wdata = 32'h1234_5678;
        @(negedge clk);
        check("t2_wr_gnt", data_gnt, 1);
        step();
        data_we = 1'b0; data_be = 4'hF;
        @(negedge clk);
        check("t2_wr_rvalid", data_rvalid, 1);
        step();
        data_req = 1'b0;
        @(negedge clk);
        check("t2_rd_rvalid", data_rvalid, 1);
        check("t2_rd_rdata", data_rdata, 32'hFFFF_5678);

        // 3: sustained contention after a lone instr grant
        step();
        instr_req = 1'b1; instr_addr = Base;
        step();
        data_req = 1'b1; data_we = 1'b0; data_addr = Base + 32'd12;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_seq = "DIDIDIDIDI";
`else
        exp_seq = "DDDDIDDDDI";
`endif
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got_c = data_gnt ? 8'h44 : (instr_gnt ? 8'h49 : 8'h2D);
            check("t3_grant_order", got_c, exp_seq[8*(9-i) +: 8]);
            step();
        end
        instr_req = 1'b0; data_req = 1'b0;

        // 4: out-of-range data (top boundary) and instr (below base)
        step();
        data_req = 1'b1; data_addr = Base + 4 * Depth;
        @(negedge clk);
        check("t4_gnt", data_gnt, 1);
        check("t4_ram_req", ram_req, 0);
        step();
        data_req = 1'b0; instr_req = 1'b1; instr_addr = Base - 32'd4;
        @(negedge clk);
        check("t4_rvalid", data_rvalid, 1);
        check("t4_err", data_err, 1);
        check("t4_rdata", data_rdata, 0);
        check("t4_lo_ram_req", ram_req, 0);
        step();
        instr_req = 1'b0;
        @(negedge clk);
        check("t4_lo_err", instr_err, 1);

        // 5: reset the cycle after a data grant
        step();
        data_req = 1'b1; data_addr = Base + 32'd8;
        @(negedge clk);
        check("t5_gnt", data_gnt, 1);
        step();
        rst = 1'b1; data_req = 1'b0;
        @(negedge clk);
        check("t5_rvalid_in_rst", data_rvalid, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t5_rvalid_after", data_rvalid, 0);

        // 6: alternating lone instr/data grants every cycle
        for (int i = 0; i < 64; i++) begin
            step();
            if (i % 2 == 0) begin
                data_req = 1'b0; instr_req = 1'b1;
                instr_addr = Base + 32'(4 * ((i * 5) % Depth));
            end else begin
                instr_req = 1'b0; data_req = 1'b1;
                data_we = (i % 4 == 1);
                data_be = 4'(i) | 4'b0001;
                data_addr = Base + 32'(4 * ((i * 3) % 16));
                data_wdata = 32'hC0DE_0000 + 32'(i);
            end
        end
        step();
        instr_req = 1'b0; data_req = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
